// File: rtl/count_monitor_if.sv
// Bus between a counter-class producer and the count_monitor checker:
// the sampled count, its qualifier, the statistics clear and the monitor status.
interface count_monitor_if #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
);
    logic [WIDTH-1:0]      count_in;
    logic                  count_valid;
    logic                  clear;

    logic                  locked;
    logic                  wrap_pulse;
    logic                  err_pulse;
    logic                  err_sticky;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0]      last_good;

    // Producer / host side
    modport master (
        output count_in, count_valid, clear,
        input  locked, wrap_pulse, err_pulse, err_sticky,
               err_count, wrap_count, last_good
    );

    // Monitor side
    modport slave (
        input  count_in, count_valid, clear,
        output locked, wrap_pulse, err_pulse, err_sticky,
               err_count, wrap_count, last_good
    );
endinterface

// File: rtl/count_monitor.sv
// Sequence checker for a free-running counter: tracks +1 mod 2^WIDTH progress,
// declares lock after SYNC_LEN good increments, and keeps saturating error/wrap stats.
module count_monitor #(
    parameter int WIDTH      = 4,
    parameter int SYNC_LEN   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    count_monitor_if.slave mon
);
    // SYNC_LEN is limited to 1..15, so four bits always hold the run length
    localparam int RUN_W = 4;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] SYNC_TGT = RUN_W'(SYNC_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [RUN_W-1:0]      good_run_q, good_run_d;
    logic [WIDTH-1:0]      last_good_q, last_good_d;
    logic                  locked_q, locked_d;
    logic                  wrap_pulse_q, wrap_pulse_d;
    logic                  err_pulse_q, err_pulse_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;

    logic [WIDTH-1:0]      prev_succ;
    logic [RUN_W-1:0]      run_inc;
    logic                  is_inc;
    logic                  is_hold;
    logic                  is_wrap;
    logic                  err_evt;
    logic                  wrap_evt;
    logic [ERR_CNT_W-1:0]  err_base;
    logic [WRAP_CNT_W-1:0] wrap_base;

    // Sample classification against the last tracked value
    always_comb begin
        prev_succ = prev_q + WIDTH'(1);
        run_inc   = good_run_q + RUN_W'(1);
        is_inc    = (mon.count_in == prev_succ);
        is_hold   = (mon.count_in == prev_q);
        is_wrap   = is_inc && (prev_q == CNT_MAX) && (mon.count_in == '0);
    end

    // Tracking FSM
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_run_d  = good_run_q;
        last_good_d = last_good_q;
        err_evt     = 1'b0;
        wrap_evt    = 1'b0;

        if (mon.count_valid) begin
            unique case (state_q)
                IDLE: begin
                    prev_d     = mon.count_in;
                    good_run_d = '0;
                    state_d    = ACQ;
                end
                ACQ: begin
                    if (is_inc) begin
                        prev_d      = mon.count_in;
                        last_good_d = mon.count_in;
                        good_run_d  = run_inc;
                        wrap_evt    = is_wrap;
                        if (run_inc == SYNC_TGT) begin
                            state_d = LOCK;
                        end
                    end else if (!is_hold) begin
                        // Out-of-sequence while acquiring just restarts the run
                        prev_d     = mon.count_in;
                        good_run_d = '0;
                    end
                end
                LOCK: begin
                    if (is_inc) begin
                        prev_d      = mon.count_in;
                        last_good_d = mon.count_in;
                        wrap_evt    = is_wrap;
                    end else if (!is_hold) begin
                        err_evt    = 1'b1;
                        prev_d     = mon.count_in;
                        good_run_d = '0;
                        state_d    = ACQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Statistics: clear lands first, then a same-cycle event counts on top of it
    always_comb begin
        err_base  = mon.clear ? '0 : err_count_q;
        wrap_base = mon.clear ? '0 : wrap_count_q;

        err_count_d = err_base;
        if (err_evt && (err_base != '1)) begin
            err_count_d = err_base + ERR_CNT_W'(1);
        end

        wrap_count_d = wrap_base;
        if (wrap_evt && (wrap_base != '1)) begin
            wrap_count_d = wrap_base + WRAP_CNT_W'(1);
        end

        err_sticky_d = (err_sticky_q && !mon.clear) || err_evt;
        err_pulse_d  = err_evt;
        wrap_pulse_d = wrap_evt;
        locked_d     = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            good_run_q   <= '0;
            last_good_q  <= '0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            last_good_q  <= last_good_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign mon.locked     = locked_q;
    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.err_count  = err_count_q;
    assign mon.wrap_count = wrap_count_q;
    assign mon.last_good  = last_good_q;
endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor (ERR_CNT_W=2 so error saturation is reachable).
module tb_count_monitor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    count_monitor_if #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8)) bus ();

    count_monitor #(
        .WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(2), .WRAP_CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for one edge; returns 1 time unit after that edge.
    task automatic step(input logic v, input logic [3:0] val, input logic clr);
        bus.count_valid = v;
        bus.count_in    = val;
        bus.clear       = clr;
        @(posedge clk);
        #1;
        bus.count_valid = 1'b0;
        bus.clear       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({bus.locked, bus.wrap_pulse, bus.err_pulse, bus.err_sticky,
             bus.err_count, bus.wrap_count, bus.last_good} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs locked=%0d wp=%0d ep=%0d es=%0d ec=%0d wc=%0d lg=%0d exp all 0",
                     bus.locked, bus.wrap_pulse, bus.err_pulse, bus.err_sticky,
                     bus.err_count, bus.wrap_count, bus.last_good);
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        step(1'b1, 4'd0, 1'b0);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_s0 locked=%0d exp=0", bus.locked); end
        step(1'b1, 4'd1, 1'b0);
        checks++;
        if (bus.locked !== 1'b0 || bus.last_good !== 4'd1) begin
            errors++; $display("FAIL lock_s1 locked=%0d lg=%0d exp 0/1", bus.locked, bus.last_good);
        end
        step(1'b1, 4'd2, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.last_good !== 4'd2 || bus.err_count !== 2'd0) begin
            errors++; $display("FAIL lock_s2 locked=%0d lg=%0d ec=%0d exp 1/2/0",
                               bus.locked, bus.last_good, bus.err_count);
        end
    endtask

    task automatic test_wrap();
        for (int v = 3; v <= 15; v++) begin
            step(1'b1, 4'(v), 1'b0);
            checks++;
            if (bus.wrap_pulse !== 1'b0 || bus.err_pulse !== 1'b0 || bus.locked !== 1'b1) begin
                errors++; $display("FAIL wrap_pre v=%0d wp=%0d ep=%0d locked=%0d exp 0/0/1",
                                   v, bus.wrap_pulse, bus.err_pulse, bus.locked);
            end
        end
        step(1'b1, 4'd0, 1'b0);
        checks++;
        if (bus.wrap_pulse !== 1'b1 || bus.wrap_count !== 8'd1 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL wrap_event wp=%0d wc=%0d locked=%0d exp 1/1/1",
                               bus.wrap_pulse, bus.wrap_count, bus.locked);
        end
        step(1'b1, 4'd1, 1'b0);
        checks++;
        if (bus.wrap_pulse !== 1'b0 || bus.wrap_count !== 8'd1 || bus.last_good !== 4'd1) begin
            errors++; $display("FAIL wrap_after wp=%0d wc=%0d lg=%0d exp 0/1/1",
                               bus.wrap_pulse, bus.wrap_count, bus.last_good);
        end
    endtask

    task automatic test_error_relock();
        for (int v = 2; v <= 5; v++) step(1'b1, 4'(v), 1'b0);
        step(1'b1, 4'd9, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b1 || bus.err_sticky !== 1'b1 || bus.err_count !== 2'd1 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL err_event ep=%0d es=%0d ec=%0d locked=%0d exp 1/1/1/0",
                               bus.err_pulse, bus.err_sticky, bus.err_count, bus.locked);
        end
        step(1'b1, 4'd10, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL err_relock1 ep=%0d locked=%0d exp 0/0", bus.err_pulse, bus.locked);
        end
        step(1'b1, 4'd11, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 2'd1 || bus.last_good !== 4'd11) begin
            errors++; $display("FAIL err_relock2 locked=%0d ec=%0d lg=%0d exp 1/1/11",
                               bus.locked, bus.err_count, bus.last_good);
        end
    endtask

    task automatic test_hold_gap();
        // 12..15,0..3 in sequence (passes one more wrap)
        for (int v = 12; v <= 19; v++) step(1'b1, 4'(v), 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'd3, 1'b0);
            checks++;
            if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1 || bus.last_good !== 4'd3) begin
                errors++; $display("FAIL hold k=%0d ep=%0d locked=%0d lg=%0d exp 0/1/3",
                                   k, bus.err_pulse, bus.locked, bus.last_good);
            end
        end
        step(1'b1, 4'd4, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.last_good !== 4'd4 || bus.wrap_count !== 8'd2) begin
            errors++; $display("FAIL hold_inc ep=%0d lg=%0d wc=%0d exp 0/4/2",
                               bus.err_pulse, bus.last_good, bus.wrap_count);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'd12, 1'b0);
            checks++;
            if (bus.locked !== 1'b1 || bus.last_good !== 4'd4 || bus.err_pulse !== 1'b0 ||
                bus.wrap_pulse !== 1'b0 || bus.err_count !== 2'd1 || bus.wrap_count !== 8'd2) begin
                errors++; $display("FAIL gap k=%0d locked=%0d lg=%0d ep=%0d wp=%0d ec=%0d wc=%0d exp 1/4/0/0/1/2",
                                   k, bus.locked, bus.last_good, bus.err_pulse, bus.wrap_pulse,
                                   bus.err_count, bus.wrap_count);
            end
        end
        step(1'b1, 4'd5, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.last_good !== 4'd5 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL gap_resume ep=%0d lg=%0d locked=%0d exp 0/5/1",
                               bus.err_pulse, bus.last_good, bus.locked);
        end
    endtask

    task automatic test_saturation_clear();
        // Each round: jump +8 (error), then two increments relock
        logic [3:0] p;
        logic [1:0] exp_ec [5];
        exp_ec = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        p = 4'd5;
        for (int r = 0; r < 5; r++) begin
            step(1'b1, p + 4'd8, 1'b0);
            checks++;
            if (bus.err_pulse !== 1'b1 || bus.err_count !== exp_ec[r]) begin
                errors++; $display("FAIL sat r=%0d ep=%0d ec=%0d exp 1/%0d",
                                   r, bus.err_pulse, bus.err_count, exp_ec[r]);
            end
            step(1'b1, p + 4'd9, 1'b0);
            step(1'b1, p + 4'd10, 1'b0);
            p = p + 4'd10;
        end
        checks++;
        if (bus.locked !== 1'b1 || bus.last_good !== 4'd7 || bus.err_count !== 2'd3) begin
            errors++; $display("FAIL sat_end locked=%0d lg=%0d ec=%0d exp 1/7/3",
                               bus.locked, bus.last_good, bus.err_count);
        end
        step(1'b0, 4'd0, 1'b1);
        checks++;
        if (bus.err_count !== 2'd0 || bus.err_sticky !== 1'b0 || bus.wrap_count !== 8'd0 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL clear ec=%0d es=%0d wc=%0d locked=%0d exp 0/0/0/1",
                               bus.err_count, bus.err_sticky, bus.wrap_count, bus.locked);
        end
        // Bad jump 7 -> 0 with clear: an error, not a wrap
        step(1'b1, 4'd0, 1'b1);
        checks++;
        if (bus.err_count !== 2'd1 || bus.err_sticky !== 1'b1 || bus.err_pulse !== 1'b1 ||
            bus.wrap_pulse !== 1'b0 || bus.wrap_count !== 8'd0 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL clear_err ec=%0d es=%0d ep=%0d wp=%0d wc=%0d locked=%0d exp 1/1/1/0/0/0",
                               bus.err_count, bus.err_sticky, bus.err_pulse, bus.wrap_pulse,
                               bus.wrap_count, bus.locked);
        end
    endtask

    task automatic test_reset_mid();
        // From prev=0: samples 1..64 relock and wrap at 16, 32, 48, 64
        for (int n = 1; n <= 64; n++) step(1'b1, 4'(n), 1'b0);
        checks++;
        if (bus.wrap_count !== 8'd4 || bus.locked !== 1'b1 || bus.last_good !== 4'd0) begin
            errors++; $display("FAIL pre_rst wc=%0d locked=%0d lg=%0d exp 4/1/0",
                               bus.wrap_count, bus.locked, bus.last_good);
        end
        rst = 1'b1;
        step(1'b1, 4'd1, 1'b0);
        rst = 1'b0;
        checks++;
        if ({bus.locked, bus.wrap_pulse, bus.err_pulse, bus.err_sticky,
             bus.err_count, bus.wrap_count, bus.last_good} !== 18'd0) begin
            errors++; $display("FAIL mid_rst locked=%0d wp=%0d ep=%0d es=%0d ec=%0d wc=%0d lg=%0d exp all 0",
                               bus.locked, bus.wrap_pulse, bus.err_pulse, bus.err_sticky,
                               bus.err_count, bus.wrap_count, bus.last_good);
        end
        step(1'b1, 4'd8, 1'b0);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL relock_a locked=%0d exp=0", bus.locked); end
        step(1'b1, 4'd9, 1'b0);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL relock_b locked=%0d exp=0", bus.locked); end
        step(1'b1, 4'd10, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.last_good !== 4'd10 || bus.err_count !== 2'd0) begin
            errors++; $display("FAIL relock_c locked=%0d lg=%0d ec=%0d exp 1/10/0",
                               bus.locked, bus.last_good, bus.err_count);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.count_in    = '0;
        bus.count_valid = 1'b0;
        bus.clear       = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_error_relock();
        test_hold_gap();
        test_saturation_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
